// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module      : io_responder
// Description : Memory-mapped switch/LED responder for the core's data bus,
//               with wait states, ready strobe and switch debouncing.
//               Optional IO_SW_CHANGE_EN adds a sticky switch-change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module io_responder #(
    parameter logic [63:0] SW_ADDR         = 64'd1024,
    parameter logic [63:0] LED_ADDR        = 64'd1032,
    parameter int          WAIT_STATES     = 1,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] alu_result,
    input  logic [63:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [63:0] read_data,
    output logic        ready,
    input  logic [17:0] switches,
    output logic [26:0] leds,
    output logic        sw_changed
);

    localparam logic [3:0]  c_wait_load = 4'(WAIT_STATES - 1);
    localparam logic [15:0] c_db_last   = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_wait_cnt;
    logic        r_is_led;
    logic        r_is_write;
    logic        r_both;
    logic [26:0] r_wdata;
    logic [63:0] r_read_data;
    logic        r_ready;
    logic [26:0] r_leds;

    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;
    logic [17:0] r_sw_cand;
    logic [17:0] r_sw_db;
    logic [15:0] r_db_cnt;

    logic w_sel;
    logic w_is_led;
    logic w_is_write;
    logic w_both;
    logic w_unused;

    assign w_unused = ^write_data[63:27];

    assign w_sel = (MemRead | MemWrite) &
                   ((alu_result == SW_ADDR) | (alu_result == LED_ADDR));

    // The response data is registered on entry to RESP, so with zero wait
    // states the live request must be used instead of the captured copy.
    assign w_is_led   = (r_state == S_IDLE) ? (alu_result == LED_ADDR) : r_is_led;
    assign w_is_write = (r_state == S_IDLE) ? MemWrite : r_is_write;
    assign w_both     = (r_state == S_IDLE) ? (MemRead & MemWrite) : r_both;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_sel) w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = S_RESP;
            S_RESP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_is_led    <= 1'b0;
            r_is_write  <= 1'b0;
            r_both      <= 1'b0;
            r_wdata     <= 27'd0;
            r_read_data <= 64'd0;
            r_ready     <= 1'b0;
            r_leds      <= 27'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_sel) begin
                r_is_led   <= (alu_result == LED_ADDR);
                r_is_write <= MemWrite;
                r_both     <= MemRead & MemWrite;
                r_wdata    <= write_data[26:0];
                r_wait_cnt <= c_wait_load;
            end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            r_ready <= (w_state_nxt == S_RESP);
            if (w_state_nxt == S_RESP) begin
                if (w_both)
                    r_read_data <= 64'd0;
                else if (!w_is_write)
                    r_read_data <= w_is_led ? {37'd0, r_leds} : {46'd0, r_sw_db};
            end
            if (r_state == S_RESP && r_is_write && r_is_led)
                r_leds <= r_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_meta <= 18'd0;
            r_sw_sync <= 18'd0;
            r_sw_cand <= 18'd0;
            r_sw_db   <= 18'd0;
            r_db_cnt  <= 16'd0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync != r_sw_cand) begin
                r_sw_cand <= r_sw_sync;
                r_db_cnt  <= 16'd0;
            end else if (r_db_cnt == c_db_last) begin
                r_sw_db <= r_sw_cand;
            end else if (r_db_cnt != 16'hFFFF) begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end

`ifdef IO_SW_CHANGE_EN
    logic r_sw_changed;
    logic w_db_update;
    logic w_sw_read_resp;

    assign w_db_update    = (r_sw_sync == r_sw_cand) && (r_db_cnt == c_db_last) &&
                            (r_sw_cand != r_sw_db);
    assign w_sw_read_resp = (r_state == S_RESP) && !r_is_write && !r_is_led;

    // Set has priority so a change landing on the clearing read is not lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_sw_changed <= 1'b0;
        else if (w_db_update)
            r_sw_changed <= 1'b1;
        else if (w_sw_read_resp)
            r_sw_changed <= 1'b0;
    end

    assign sw_changed = r_sw_changed;
`else
    assign sw_changed = 1'b0;
`endif

    assign read_data = r_read_data;
    assign ready     = r_ready;
    assign leds      = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_responder
// Description : Self-checking bench for io_responder (table vectors, directed
//               corner cases and randomized transactions against a model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_responder;

    localparam int          WS    = 1;
    localparam int          DB    = 16;
    localparam logic [63:0] SW_A  = 64'd1024;
    localparam logic [63:0] LED_A = 64'd1032;
`ifdef IO_SW_CHANGE_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] alu_result = 64'd0;
    logic [63:0] write_data = 64'd0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [17:0] switches = 18'd0;
    logic [63:0] read_data;
    logic        ready;
    logic [26:0] leds;
    logic        sw_changed;
    logic [63:0] read_data0;
    logic        ready0;
    logic [26:0] leds0;
    logic        sw_changed0;

    io_responder #(.SW_ADDR(SW_A), .LED_ADDR(LED_A), .WAIT_STATES(WS),
                   .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset), .alu_result(alu_result),
        .write_data(write_data), .MemRead(MemRead), .MemWrite(MemWrite),
        .read_data(read_data), .ready(ready), .switches(switches),
        .leds(leds), .sw_changed(sw_changed));

    // Zero-wait-state instance sharing the stimulus, used for the
    // back-to-back throughput case.
    io_responder #(.SW_ADDR(SW_A), .LED_ADDR(LED_A), .WAIT_STATES(0),
                   .DEBOUNCE_CYCLES(DB)) dut0 (
        .clock(clock), .reset(reset), .alu_result(alu_result),
        .write_data(write_data), .MemRead(MemRead), .MemWrite(MemWrite),
        .read_data(read_data0), .ready(ready0), .switches(switches),
        .leds(leds0), .sw_changed(sw_changed0));

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [26:0] leds_m = 27'd0;
    logic [63:0] rd_m   = 64'd0;
    logic [17:0] db_m   = 18'd0;
    logic        flag_m = 1'b0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
        logic [26:0] exp_leds;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic xact(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdat);
        int lat;
        bit seen;
        MemRead = rd; MemWrite = wr; alu_result = addr; write_data = wdata;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            tick();
            lat++;
            seen = ready;
        end
        rdat = read_data;
        MemRead = 1'b0; MemWrite = 1'b0;
        check("ready_latency", 64'(lat), 64'(WS + 1));
        if (rd && wr)           rd_m = 64'd0;
        else if (rd)            rd_m = (addr == LED_A) ? {37'd0, leds_m} : {46'd0, db_m};
        if (wr && addr == LED_A) leds_m = wdata[26:0];
        if (rd && !wr && addr == SW_A) flag_m = 1'b0;
        check("read_data", read_data, rd_m);
        tick();
        check("ready_one_cycle", {63'd0, ready}, 64'd0);
        check("leds", {37'd0, leds}, {37'd0, leds_m});
        check("sw_changed", {63'd0, sw_changed}, {63'd0, flag_m});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rdat;
        logic [63:0] rd_before;
        logic [17:0] new_sw;
        bit any_ready;

        vecs[0] = '{1'b0, 1'b1, LED_A, 64'h5A5A5A,            64'h0,       27'h5A5A5A};
        vecs[1] = '{1'b1, 1'b0, LED_A, 64'h0,                 64'h5A5A5A,  27'h5A5A5A};
        vecs[2] = '{1'b0, 1'b1, SW_A,  64'hFFFF,              64'h5A5A5A,  27'h5A5A5A};
        vecs[3] = '{1'b1, 1'b0, SW_A,  64'h0,                 64'h0,       27'h5A5A5A};
        vecs[4] = '{1'b1, 1'b1, LED_A, 64'h123,               64'h0,       27'h123};
        vecs[5] = '{1'b0, 1'b1, LED_A, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,     27'h7FFFFFF};
        vecs[6] = '{1'b1, 1'b0, LED_A, 64'h0,                 64'h7FFFFFF, 27'h7FFFFFF};
        vecs[7] = '{1'b1, 1'b1, SW_A,  64'h55,                64'h0,       27'h7FFFFFF};

        // Reset state
        tick(); tick();
        check("rst_read_data", read_data, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_leds", {37'd0, leds}, 64'd0);
        check("rst_sw_changed", {63'd0, sw_changed}, 64'd0);
        reset = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            xact(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdat);
            check($sformatf("tbl%0d_rdata", i), rdat, vecs[i].exp_rd);
            check($sformatf("tbl%0d_leds", i), {37'd0, leds}, {37'd0, vecs[i].exp_leds});
        end

        // Debounce, then glitch rejection
        switches = 18'h2AAAA;
        repeat (DB + 4) tick();
        db_m = 18'h2AAAA;
        flag_m = FLAG_EN;
        check("sw_changed_set", {63'd0, sw_changed}, {63'd0, flag_m});
        xact(1'b1, 1'b0, SW_A, 64'd0, rdat);
        check("sw_debounced", rdat, 64'h2AAAA);
        switches = 18'h3FFFF;
        repeat (3) tick();
        switches = 18'h2AAAA;
        repeat (DB + 4) tick();
        check("glitch_no_flag", {63'd0, sw_changed}, 64'd0);
        xact(1'b1, 1'b0, SW_A, 64'd0, rdat);
        check("glitch_rejected", rdat, 64'h2AAAA);

        // Unmapped address is ignored
        rd_before = rd_m;
        any_ready = 1'b0;
        MemRead = 1'b1; alu_result = 64'd2000;
        repeat (10) begin
            tick();
            if (ready) any_ready = 1'b1;
        end
        MemRead = 1'b0;
        check("bad_addr_ready", {63'd0, any_ready}, 64'd0);
        check("bad_addr_rdata", read_data, rd_before);

        // Zero wait states, request held continuously: one response every 2nd cycle
        MemRead = 1'b1; alu_result = LED_A;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("b2b_ready_%0d", i), {63'd0, ready0}, 64'(i % 2));
            if (ready0) check("b2b_rdata", read_data0, {37'd0, leds_m});
        end
        MemRead = 1'b0;
        repeat (5) tick();
        rd_m = {37'd0, leds_m};

        // Reset asserted during WAIT of an LED store
        MemWrite = 1'b1; alu_result = LED_A; write_data = 64'h1ABCDE;
        tick();
        reset = 1'b0;
        #1;
        check("abort_ready", {63'd0, ready}, 64'd0);
        check("abort_leds", {37'd0, leds}, 64'd0);
        MemWrite = 1'b0;
        tick(); tick();
        check("abort_ready_hold", {63'd0, ready}, 64'd0);
        check("abort_leds_hold", {37'd0, leds}, 64'd0);
        check("abort_rdata", read_data, 64'd0);
        reset = 1'b1;
        leds_m = 27'd0; rd_m = 64'd0; db_m = 18'd0; flag_m = 1'b0;
        tick();
        xact(1'b0, 1'b1, LED_A, 64'h1ABCDE, rdat);
        check("post_reset_leds", {37'd0, leds}, 64'h1ABCDE);
        repeat (DB + 8) tick();
        db_m = switches;
        flag_m = FLAG_EN;
        check("post_reset_flag", {63'd0, sw_changed}, {63'd0, flag_m});

        // Randomized transactions against the model
        for (int it = 0; it < 40; it++) begin
            int op;
            if (it % 10 == 0) begin
                new_sw = 18'($urandom);
                if (new_sw != db_m && FLAG_EN) flag_m = 1'b1;
                switches = new_sw;
                repeat (DB + 4) tick();
                db_m = new_sw;
                check("rnd_flag", {63'd0, sw_changed}, {63'd0, flag_m});
            end
            op = $urandom_range(0, 4);
            case (op)
                0: xact(1'b1, 1'b0, SW_A, 64'd0, rdat);
                1: xact(1'b1, 1'b0, LED_A, 64'd0, rdat);
                2: xact(1'b0, 1'b1, LED_A, {$urandom, $urandom}, rdat);
                3: xact(1'($urandom_range(0, 1)), 1'b1,
                        $urandom_range(0, 1) ? SW_A : LED_A, {$urandom, $urandom}, rdat);
                default: begin
                    any_ready = 1'b0;
                    MemRead = 1'($urandom_range(0, 1));
                    MemWrite = ~MemRead;
                    alu_result = 64'd2000 + 64'($urandom_range(0, 100)) * 64'd8;
                    repeat (4) begin
                        tick();
                        if (ready) any_ready = 1'b1;
                    end
                    MemRead = 1'b0; MemWrite = 1'b0;
                    check("rnd_bad_ready", {63'd0, any_ready}, 64'd0);
                    check("rnd_bad_rdata", read_data, rd_m);
                    check("rnd_bad_leds", {37'd0, leds}, {37'd0, leds_m});
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
